// File: rtl/genius_pkg.sv
// Shared definitions for the Genius LED sequence player: sizes, colour and
// rate encodings, playback states and the colour-to-LED decode.
package genius_pkg;

    localparam int MAX_LEN = 16;
    localparam int SW      = $clog2(MAX_LEN + 1);
    localparam int IW      = $clog2(MAX_LEN);

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] RED    = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;
    localparam logic [1:0] BLUE   = 2'b11;

    localparam logic [1:0] RATE_025 = 2'd0;
    localparam logic [1:0] RATE_05  = 2'd1;
    localparam logic [1:0] RATE_1   = 2'd2;
    localparam logic [1:0] RATE_2   = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        ON     = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4
    } state_t;

    function automatic logic [3:0] colour_onehot(input logic [1:0] col);
        logic [3:0] oh;
        case (col)
            GREEN:   oh = 4'b0001;
            RED:     oh = 4'b0010;
            YELLOW:  oh = 4'b0100;
            BLUE:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/genius_edge_sync.sv
// Brings one slow rate clock into clk_50MHz through two flops, then compares
// against a history flop to flag rising and falling edges.
module genius_edge_sync
    import genius_pkg::*;
(
    input  logic clk_50MHz,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    // Next-state of the synchronizer chain and history flop.
    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~hist_q;
    assign fall  = ~sync2_q & hist_q;

endmodule

// File: rtl/genius_sequence_player.sv
// Plays a latched colour sequence on the four Genius LEDs, one step per high
// phase of the selected rate clock, dark during each low phase.
module genius_sequence_player
    import genius_pkg::*;
(
    input  logic                   clk_50MHz,
    input  logic                   reset,
    input  logic [3:0]             rate_clk,
    input  logic [1:0]             rate_sel,
    input  logic                   start,
    input  logic [SW-1:0]          seq_len,
    input  logic [2*MAX_LEN-1:0]   seq_data,
    output logic [3:0]             led,
    output logic                   busy,
    output logic                   done,
    output logic [SW-1:0]          step_idx
);

    logic [3:0] rise_s;
    logic [3:0] fall_s;
    logic [3:0] level_unused_s;

    for (genvar g = 0; g < 4; g++) begin : g_sync
        genius_edge_sync u_sync (
            .clk_50MHz (clk_50MHz),
            .reset     (reset),
            .d         (rate_clk[g]),
            .level     (level_unused_s[g]),
            .rise      (rise_s[g]),
            .fall      (fall_s[g])
        );
    end

    state_t                 state_q,    state_d;
    logic [1:0]             sel_q,      sel_d;
    logic [SW-1:0]          len_q,      len_d;
    logic [2*MAX_LEN-1:0]   data_q,     data_d;
    logic [3:0]             led_q,      led_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic [SW-1:0]          step_idx_q, step_idx_d;

    logic                   sel_rise_s;
    logic                   sel_fall_s;
    logic [SW-1:0]          len_clamp_s;
    logic [1:0]             step_col_s;

    // Edge select, requested-length clamp and current step colour lookup.
    always_comb begin
        sel_rise_s  = rise_s[sel_q];
        sel_fall_s  = fall_s[sel_q];
        len_clamp_s = (seq_len > SW'(MAX_LEN)) ? SW'(MAX_LEN) : seq_len;
        step_col_s  = data_q[{step_idx_q[IW-1:0], 1'b0} +: 2];
    end

    // Playback FSM: next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        len_d      = len_q;
        data_d     = data_q;
        led_d      = led_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        step_idx_d = step_idx_q;

        case (state_q)
            IDLE: begin
                led_d  = 4'b0000;
                busy_d = 1'b0;
                if (start) begin
                    sel_d      = rate_sel;
                    data_d     = seq_data;
                    len_d      = len_clamp_s;
                    step_idx_d = {SW{1'b0}};
                    if (len_clamp_s == {SW{1'b0}}) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ARM;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            // A rise seen straight after reset release is accepted as real.
            ARM: begin
                if (sel_rise_s) begin
                    state_d = ON;
                    led_d   = colour_onehot(step_col_s);
                end else begin
                    state_d = ARM;
                end
            end
            ON: begin
                if (sel_fall_s) begin
                    led_d = 4'b0000;
                    if (step_idx_q == (len_q - SW'(1))) begin
                        state_d = FINISH;
                    end else begin
                        step_idx_d = step_idx_q + SW'(1);
                        state_d    = GAP;
                    end
                end else begin
                    state_d = ON;
                end
            end
            GAP: begin
                led_d = 4'b0000;
                if (sel_rise_s) begin
                    state_d = ON;
                    led_d   = colour_onehot(step_col_s);
                end else begin
                    state_d = GAP;
                end
            end
            FINISH: begin
                led_d   = 4'b0000;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                led_d   = 4'b0000;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and output registers.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= 2'b00;
            len_q      <= {SW{1'b0}};
            data_q     <= {(2*MAX_LEN){1'b0}};
            led_q      <= 4'b0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            step_idx_q <= {SW{1'b0}};
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            len_q      <= len_d;
            data_q     <= data_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            step_idx_q <= step_idx_d;
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_idx_q;

endmodule

// File: tb/tb_genius_sequence_player.sv
// Directed bench for genius_sequence_player: drives rate_clk[2] by hand and
// checks LED timing, done/busy handshakes, clamping, ignored starts and reset.
module tb_genius_sequence_player;
    import genius_pkg::*;

    logic                 clk_50MHz;
    logic                 reset;
    logic [3:0]           rate_clk;
    logic [1:0]           rate_sel;
    logic                 start;
    logic [SW-1:0]        seq_len;
    logic [2*MAX_LEN-1:0] seq_data;
    logic [3:0]           led;
    logic                 busy;
    logic                 done;
    logic [SW-1:0]        step_idx;

    int n_checks = 0;
    int n_fails  = 0;
    logic [3:0] led_exp = 4'b0000;

    genius_sequence_player dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .rate_clk  (rate_clk),
        .rate_sel  (rate_sel),
        .start     (start),
        .seq_len   (seq_len),
        .seq_data  (seq_data),
        .led       (led),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx)
    );

    initial begin
        clk_50MHz = 1'b0;
        forever #10 clk_50MHz = ~clk_50MHz;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50MHz);
            #1;
        end
    endtask

    // Moves rate_clk[2]; LED must keep its old value for two edges and take
    // the new one on the third.
    task automatic rate_half(input logic v, input logic [3:0] exp_led, input int hold);
        rate_clk[2] = v;
        tick(2);
        check_eq("led_before_edge", {28'd0, led}, {28'd0, led_exp});
        tick(1);
        led_exp = exp_led;
        check_eq("led_after_edge", {28'd0, led}, {28'd0, led_exp});
        tick(hold - 3);
    endtask

    task automatic pulse_start(input logic [1:0] sel, input logic [SW-1:0] len,
                               input logic [2*MAX_LEN-1:0] data);
        rate_sel = sel;
        seq_len  = len;
        seq_data = data;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_led"},  {28'd0, led},  32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_idx"},  {27'd0, step_idx}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        rate_clk = 4'b1111;
        rate_sel = 2'd0;
        start    = 1'b0;
        seq_len  = 5'd0;
        seq_data = 32'd0;

        // Reset with all rate clocks high
        tick(3);
        check_idle("rst");
        reset = 1'b0;
        tick(6);
        check_idle("no_start");
        rate_clk = 4'b0000;
        tick(5);

        // Three-step playback: GREEN, RED, BLUE at the 1 Hz rate
        pulse_start(RATE_1, 5'd3, {26'd0, BLUE, RED, GREEN});
        check_eq("p1_busy_start", {31'd0, busy}, 32'd1);
        check_eq("p1_idx_start", {27'd0, step_idx}, 32'd0);
        tick(4);
        rate_half(1'b1, 4'b0001, 20);
        check_eq("p1_idx0", {27'd0, step_idx}, 32'd0);
        rate_half(1'b0, 4'b0000, 20);
        check_eq("p1_idx1", {27'd0, step_idx}, 32'd1);
        rate_half(1'b1, 4'b0010, 20);
        rate_half(1'b0, 4'b0000, 20);
        rate_half(1'b1, 4'b1000, 20);
        check_eq("p1_busy_mid", {31'd0, busy}, 32'd1);
        check_eq("p1_done_mid", {31'd0, done}, 32'd0);
        rate_half(1'b0, 4'b0000, 3);
        check_eq("p1_busy_fin", {31'd0, busy}, 32'd1);
        check_eq("p1_done_fin", {31'd0, done}, 32'd0);
        tick(1);
        check_eq("p1_done", {31'd0, done}, 32'd1);
        check_eq("p1_busy_done", {31'd0, busy}, 32'd0);
        check_eq("p1_idx_last", {27'd0, step_idx}, 32'd2);
        tick(1);
        check_eq("p1_done_once", {31'd0, done}, 32'd0);
        tick(5);

        // Zero-length request
        pulse_start(RATE_1, 5'd0, 32'hFFFF_FFFF);
        check_eq("z_busy", {31'd0, busy}, 32'd0);
        check_eq("z_done_early", {31'd0, done}, 32'd0);
        tick(1);
        check_eq("z_done", {31'd0, done}, 32'd1);
        check_eq("z_busy2", {31'd0, busy}, 32'd0);
        check_eq("z_led", {28'd0, led}, 32'd0);
        tick(1);
        check_eq("z_done_once", {31'd0, done}, 32'd0);
        tick(3);

        // Restart and input changes during playback are ignored
        pulse_start(RATE_1, 5'd2, {28'd0, YELLOW, GREEN});
        tick(2);
        pulse_start(RATE_025, 5'd5, 32'hFFFF_FFFF);
        tick(2);
        rate_half(1'b1, 4'b0001, 10);
        pulse_start(RATE_2, 5'd9, 32'h5555_5555);
        rate_half(1'b0, 4'b0000, 10);
        rate_half(1'b1, 4'b0100, 10);
        rate_half(1'b0, 4'b0000, 3);
        tick(1);
        check_eq("ig_done", {31'd0, done}, 32'd1);
        check_eq("ig_idx", {27'd0, step_idx}, 32'd1);
        tick(1);
        check_eq("ig_done_once", {31'd0, done}, 32'd0);
        rate_half(1'b1, 4'b0000, 8);
        rate_half(1'b0, 4'b0000, 8);
        check_eq("ig_quiet_busy", {31'd0, busy}, 32'd0);
        check_eq("ig_quiet_done", {31'd0, done}, 32'd0);

        // Over-long request clamps to MAX_LEN steps
        pulse_start(RATE_1, 5'(MAX_LEN + 5), 32'hE4E4_E4E4);
        tick(2);
        for (int i = 0; i < MAX_LEN; i++) begin
            rate_half(1'b1, 4'(4'b0001 << (i % 4)), 5);
            check_eq("cl_idx", {27'd0, step_idx}, 32'(i));
            if (i < MAX_LEN - 1) begin
                rate_half(1'b0, 4'b0000, 5);
            end else begin
                rate_half(1'b0, 4'b0000, 3);
            end
        end
        tick(1);
        check_eq("cl_done", {31'd0, done}, 32'd1);
        check_eq("cl_idx_last", {27'd0, step_idx}, 32'(MAX_LEN - 1));
        tick(1);
        check_eq("cl_busy_after", {31'd0, busy}, 32'd0);

        // Asynchronous reset while YELLOW is lit, then replay from step 0
        pulse_start(RATE_1, 5'd3, {30'd0, YELLOW});
        tick(2);
        rate_half(1'b1, 4'b0100, 10);
        check_eq("ar_led_on", {28'd0, led}, 32'h4);
        #4 reset = 1'b1;
        #1;
        check_idle("ar_async");
        tick(2);
        check_idle("ar_held");
        reset       = 1'b0;
        rate_clk[2] = 1'b0;
        led_exp     = 4'b0000;
        tick(5);
        check_idle("ar_release");
        pulse_start(RATE_1, 5'd3, {26'd0, BLUE, RED, GREEN});
        tick(2);
        rate_half(1'b1, 4'b0001, 10);
        check_eq("ar_idx0", {27'd0, step_idx}, 32'd0);
        rate_half(1'b0, 4'b0000, 10);
        check_eq("ar_idx1", {27'd0, step_idx}, 32'd1);
        rate_half(1'b1, 4'b0010, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
